// File: rtl/spatz_vrf_pkg.sv
// Shared types, sizes and address-mapping helpers for the banked vector register file.
package spatz_vrf_pkg;

    localparam int unsigned VrfNrVRegs  = 32;
    localparam int unsigned VrfNrBanks  = 4;
    localparam int unsigned VELE        = 8;
    localparam int unsigned ELEN        = 64;
    localparam int unsigned ELENB       = ELEN / 8;
    localparam int unsigned NrReadPorts = 3;

    localparam int unsigned RegW  = $clog2(VrfNrVRegs);
    localparam int unsigned WordW = $clog2(VELE);
    localparam int unsigned BankW = $clog2(VrfNrBanks);
    localparam int unsigned RowW  = RegW + WordW - BankW;

    typedef logic [RegW+WordW-1:0] vreg_addr_t;
    typedef logic [ELEN-1:0]       vreg_data_t;
    typedef logic [ELENB-1:0]      vreg_be_t;
    typedef logic [BankW-1:0]      vrf_bank_t;
    typedef logic [RowW-1:0]       vrf_row_t;

    typedef struct packed {
        logic       valid;
        logic       pending;
        vreg_addr_t addr;
        vreg_data_t data;
    } vrf_hold_t;

    // Skewed mapping: the same word of consecutive registers lands in consecutive banks.
    function automatic vrf_bank_t vrf_bank(vreg_addr_t addr);
        logic [RegW-1:0]  vreg;
        logic [WordW-1:0] word;
        vreg = addr[WordW +: RegW];
        word = addr[WordW-1:0];
        return vrf_bank_t'(vreg + RegW'(word));
    endfunction

    function automatic vrf_row_t vrf_row(vreg_addr_t addr);
        return {addr[WordW +: RegW], addr[WordW-1:BankW]};
    endfunction

    function automatic vreg_data_t vrf_merge(vreg_data_t old_data, vreg_data_t new_data,
                                             vreg_be_t be);
        vreg_data_t res;
        res = old_data;
        for (int i = 0; i < int'(ELENB); i++) begin
            if (be[i]) res[8*i +: 8] = new_data[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/spatz_vrf_if.sv
// VFU <-> VRF bundle: one byte-enabled write port and three operand read ports.
interface spatz_vrf_if;
    import spatz_vrf_pkg::*;

    vreg_addr_t                   waddr;
    vreg_data_t                   wdata;
    logic                         we;
    vreg_be_t                     wbe;
    logic                         wvalid;
    vreg_addr_t [NrReadPorts-1:0] raddr;
    logic       [NrReadPorts-1:0] re;
    vreg_data_t [NrReadPorts-1:0] rdata;
    logic       [NrReadPorts-1:0] rvalid;

    modport master (
        output waddr, wdata, we, wbe, raddr, re,
        input  wvalid, rdata, rvalid
    );

    modport slave (
        input  waddr, wdata, we, wbe, raddr, re,
        output wvalid, rdata, rvalid
    );

endinterface

// File: rtl/spatz_vrf_bank.sv
// Single-port SRAM bank with synchronous read and byte-enabled write; contents are never reset.
module spatz_vrf_bank
    import spatz_vrf_pkg::*;
#(
    parameter int unsigned NrRows = 64
) (
    input  logic       clk_i,
    input  logic       en_i,
    input  logic       we_i,
    input  vrf_row_t   row_i,
    input  vreg_data_t wdata_i,
    input  vreg_be_t   be_i,
    output vreg_data_t rdata_o
);

    vreg_data_t mem_q [NrRows];
    vreg_data_t rdata_q, rdata_d;

    // Output register holds the last read; write cycles leave it untouched.
    always_comb begin
        rdata_d = rdata_q;
        if (en_i && !we_i) rdata_d = mem_q[row_i];
    end

    always_ff @(posedge clk_i) begin
        rdata_q <= rdata_d;
        if (en_i && we_i) begin
            for (int i = 0; i < int'(ELENB); i++) begin
                if (be_i[i]) mem_q[row_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/spatz_vrf.sv
// Banked VRF with per-port operand-hold registers; writes always win bank arbitration.
// Optional SPATZ_VRF_WFWD_EN: writes merge into matching hold entries instead of invalidating them.
module spatz_vrf
    import spatz_vrf_pkg::*;
#(
    parameter int unsigned NrBanks = VrfNrBanks,
    parameter int unsigned NrVRegs = VrfNrVRegs
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    spatz_vrf_if.slave vrf
);

    localparam int unsigned BankRows = NrVRegs * VELE / NrBanks;

    vrf_hold_t [NrReadPorts-1:0] hold_q, hold_d;
    logic      [NrReadPorts-1:0] hit, req, gnt, rvalid;
    vrf_bank_t [NrReadPorts-1:0] rbank, tbank;
    vreg_data_t [NrReadPorts-1:0] rdata;
    vrf_bank_t                   wbank;
    logic                        wr_en;

    logic       [NrBanks-1:0] bank_en, bank_we;
    vrf_row_t   [NrBanks-1:0] bank_row;
    vreg_data_t [NrBanks-1:0] bank_rdata;

    always_comb begin
        wr_en = vrf.we && rst_ni;
        wbank = vrf_bank(vrf.waddr);
        for (int p = 0; p < int'(NrReadPorts); p++) begin
            rbank[p] = vrf_bank(vrf.raddr[p]);
            tbank[p] = vrf_bank(hold_q[p].addr);
            hit[p]   = vrf.re[p] && hold_q[p].valid && (hold_q[p].addr == vrf.raddr[p]);
            req[p]   = rst_ni && vrf.re[p] && !hit[p] && !hold_q[p].pending;
        end
        // Fixed priority per bank: write, then lower port index.
        for (int p = 0; p < int'(NrReadPorts); p++) begin
            gnt[p] = req[p] && !(wr_en && (wbank == rbank[p]));
            for (int q = 0; q < p; q++) begin
                if (req[q] && (rbank[q] == rbank[p])) gnt[p] = 1'b0;
            end
        end
    end

    always_comb begin
        for (int b = 0; b < int'(NrBanks); b++) begin
            bank_en[b]  = 1'b0;
            bank_we[b]  = 1'b0;
            bank_row[b] = '0;
            if (wr_en && (wbank == vrf_bank_t'(b))) begin
                bank_en[b]  = 1'b1;
                bank_we[b]  = 1'b1;
                bank_row[b] = vrf_row(vrf.waddr);
            end else begin
                for (int p = 0; p < int'(NrReadPorts); p++) begin
                    if (gnt[p] && (rbank[p] == vrf_bank_t'(b))) begin
                        bank_en[b]  = 1'b1;
                        bank_row[b] = vrf_row(vrf.raddr[p]);
                    end
                end
            end
        end
    end

    for (genvar b = 0; b < NrBanks; b++) begin : gen_bank
        spatz_vrf_bank #(
            .NrRows (BankRows)
        ) i_bank (
            .clk_i   (clk_i),
            .en_i    (bank_en[b]),
            .we_i    (bank_we[b]),
            .row_i   (bank_row[b]),
            .wdata_i (vrf.wdata),
            .be_i    (vrf.wbe),
            .rdata_o (bank_rdata[b])
        );
    end

    // A pending entry is served straight from its bank output in the capture cycle.
    always_comb begin
        for (int p = 0; p < int'(NrReadPorts); p++) begin
            rvalid[p] = rst_ni && vrf.re[p] &&
                        (hit[p] || (hold_q[p].pending && (hold_q[p].addr == vrf.raddr[p])));
            rdata[p]  = '0;
            if (rvalid[p]) rdata[p] = hold_q[p].pending ? bank_rdata[tbank[p]] : hold_q[p].data;
        end
    end

    always_comb begin
        for (int p = 0; p < int'(NrReadPorts); p++) begin
            hold_d[p] = hold_q[p];
            if (hold_q[p].pending) begin
                hold_d[p].data    = bank_rdata[tbank[p]];
                hold_d[p].valid   = 1'b1;
                hold_d[p].pending = 1'b0;
            end
            if (wr_en && hold_d[p].valid && (hold_q[p].addr == vrf.waddr)) begin
`ifdef SPATZ_VRF_WFWD_EN
                hold_d[p].data = vrf_merge(hold_d[p].data, vrf.wdata, vrf.wbe);
`else
                hold_d[p].valid = 1'b0;
`endif
            end
            if (gnt[p]) begin
                hold_d[p].pending = 1'b1;
                hold_d[p].valid   = 1'b0;
                hold_d[p].addr    = vrf.raddr[p];
            end
            if (!rst_ni) begin
                hold_d[p].valid   = 1'b0;
                hold_d[p].pending = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        hold_q <= hold_d;
    end

    assign vrf.wvalid = vrf.we;
    assign vrf.rvalid = rvalid;
    assign vrf.rdata  = rdata;

endmodule

// File: tb/tb_spatz_vrf.sv
// Directed bench for spatz_vrf: reset, hits/misses, bank conflicts, write-over-hold, group sweep.
module tb_spatz_vrf;
    import spatz_vrf_pkg::*;

    logic clk_i = 1'b0;
    logic rst_ni;
    int   tests_run    = 0;
    int   tests_failed = 0;

    spatz_vrf_if vrf_if ();

    spatz_vrf dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .vrf    (vrf_if)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic vreg_addr_t va(input int r, input int w);
        return {RegW'(r), WordW'(w)};
    endfunction

    function automatic vreg_data_t pat(input int r, input int w);
        return {8{8'(r * 16 + w)}};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    task automatic wr(input vreg_addr_t a, input vreg_data_t d);
        vrf_if.we    = 1'b1;
        vrf_if.waddr = a;
        vrf_if.wdata = d;
        vrf_if.wbe   = 8'hFF;
        sample();
        check_eq("wr_wvalid", 64'(vrf_if.wvalid), 64'd1);
        tick();
        vrf_if.we = 1'b0;
    endtask

    initial begin
        rst_ni       = 1'b0;
        vrf_if.we    = 1'b0;
        vrf_if.waddr = '0;
        vrf_if.wdata = '0;
        vrf_if.wbe   = '0;
        vrf_if.re    = 3'b111;
        vrf_if.raddr = '0;
        tick();
        repeat (2) begin
            sample();
            check_eq("rst_rvalid", 64'(vrf_if.rvalid), 64'd0);
            check_eq("rst_rdata0", vrf_if.rdata[0], 64'd0);
            tick();
        end
        rst_ni    = 1'b1;
        vrf_if.re = 3'b000;
        sample();
        check_eq("idle_wvalid", 64'(vrf_if.wvalid), 64'd0);
        tick();

        wr(va(1, 0), 64'hA5A5A5A5A5A5A5A5);
        wr(va(2, 0), pat(2, 0));
        wr(va(3, 0), pat(3, 0));
        wr(va(0, 1), pat(0, 1));
        wr(va(2, 3), pat(2, 3));

        // Aligned group in distinct banks: all valid one cycle after the request.
        vrf_if.raddr = {va(3, 0), va(1, 0), va(2, 0)};
        vrf_if.re    = 3'b111;
        sample();
        check_eq("grp_miss", 64'(vrf_if.rvalid), 64'd0);
        tick();
        sample();
        check_eq("grp_valid", 64'(vrf_if.rvalid), 64'b111);
        check_eq("grp_d0", vrf_if.rdata[0], pat(2, 0));
        check_eq("grp_d1", vrf_if.rdata[1], 64'hA5A5A5A5A5A5A5A5);
        check_eq("grp_d2", vrf_if.rdata[2], pat(3, 0));
        tick();

        for (int i = 0; i < 10; i++) begin
            sample();
            check_eq("hold_rvalid", 64'(vrf_if.rvalid), 64'b111);
            check_eq("hold_d0", vrf_if.rdata[0], pat(2, 0));
            tick();
        end

        // Partial write over the entry held by port 2.
        vrf_if.we    = 1'b1;
        vrf_if.waddr = va(3, 0);
        vrf_if.wdata = 64'h1111111111111111;
        vrf_if.wbe   = 8'h0F;
        sample();
        check_eq("rbw_wvalid", 64'(vrf_if.wvalid), 64'd1);
        check_eq("rbw_rvalid", 64'(vrf_if.rvalid), 64'b111);
        check_eq("rbw_old", vrf_if.rdata[2], pat(3, 0));
        tick();
        vrf_if.we = 1'b0;
        sample();
`ifdef SPATZ_VRF_WFWD_EN
        check_eq("fwd_rvalid", 64'(vrf_if.rvalid), 64'b111);
        check_eq("fwd_data", vrf_if.rdata[2], 64'h3030303011111111);
        tick();
`else
        check_eq("inv_rvalid", 64'(vrf_if.rvalid), 64'b011);
        tick();
        sample();
        check_eq("reread_rvalid", 64'(vrf_if.rvalid), 64'b111);
        check_eq("reread_data", vrf_if.rdata[2], 64'h3030303011111111);
        tick();
`endif

        // Reset lands in the capture cycle of a granted read.
        vrf_if.re       = 3'b001;
        vrf_if.raddr[0] = va(2, 3);
        sample();
        check_eq("mrst_grant", 64'(vrf_if.rvalid), 64'd0);
        tick();
        rst_ni = 1'b0;
        sample();
        check_eq("mrst_rvalid", 64'(vrf_if.rvalid), 64'd0);
        check_eq("mrst_rdata", vrf_if.rdata[0], 64'd0);
        tick();
        rst_ni = 1'b1;
        sample();
        check_eq("mrst_nocap", 64'(vrf_if.rvalid), 64'd0);
        tick();
        sample();
        check_eq("mrst_reread", 64'(vrf_if.rvalid), 64'b001);
        check_eq("mrst_data", vrf_if.rdata[0], pat(2, 3));
        tick();

        // Three reads plus a write all in bank 1: write first, then ports 0, 1, 2.
        vrf_if.raddr = {va(2, 3), va(1, 0), va(0, 1)};
        vrf_if.re    = 3'b111;
        vrf_if.we    = 1'b1;
        vrf_if.waddr = va(3, 2);
        vrf_if.wdata = pat(3, 2);
        vrf_if.wbe   = 8'hFF;
        sample();
        check_eq("cf_wvalid", 64'(vrf_if.wvalid), 64'd1);
        check_eq("cf_t0", 64'(vrf_if.rvalid), 64'b000);
        tick();
        vrf_if.we = 1'b0;
        sample();
        check_eq("cf_t1", 64'(vrf_if.rvalid), 64'b000);
        tick();
        sample();
        check_eq("cf_t2", 64'(vrf_if.rvalid), 64'b001);
        tick();
        sample();
        check_eq("cf_t3", 64'(vrf_if.rvalid), 64'b011);
        tick();
        sample();
        check_eq("cf_t4", 64'(vrf_if.rvalid), 64'b111);
        check_eq("cf_d0", vrf_if.rdata[0], pat(0, 1));
        check_eq("cf_d1", vrf_if.rdata[1], 64'hA5A5A5A5A5A5A5A5);
        check_eq("cf_d2", vrf_if.rdata[2], pat(2, 3));
        tick();

        vrf_if.re = 3'b000;
        for (int g = 0; g < 4; g++) begin
            for (int r = 4; r < 7; r++) wr(va(r, g), pat(r, g));
        end

        // Group sweep with a result write every cycle into the one free bank.
        for (int g = 0; g < 4; g++) begin
            vrf_if.raddr = {va(6, g), va(5, g), va(4, g)};
            vrf_if.re    = 3'b111;
            vrf_if.we    = 1'b1;
            vrf_if.waddr = va(7, g);
            vrf_if.wdata = pat(7, g);
            vrf_if.wbe   = 8'hFF;
            sample();
            check_eq("sw_wvalid_a", 64'(vrf_if.wvalid), 64'd1);
            check_eq("sw_miss", 64'(vrf_if.rvalid), 64'b000);
            tick();
            sample();
            check_eq("sw_wvalid_b", 64'(vrf_if.wvalid), 64'd1);
            check_eq("sw_valid", 64'(vrf_if.rvalid), 64'b111);
            check_eq("sw_d0", vrf_if.rdata[0], pat(4, g));
            check_eq("sw_d1", vrf_if.rdata[1], pat(5, g));
            check_eq("sw_d2", vrf_if.rdata[2], pat(6, g));
            tick();
        end
        vrf_if.we       = 1'b0;
        vrf_if.re       = 3'b001;
        vrf_if.raddr[0] = va(7, 0);
        sample();
        check_eq("res_miss", 64'(vrf_if.rvalid), 64'd0);
        tick();
        sample();
        check_eq("res_valid", 64'(vrf_if.rvalid), 64'b001);
        check_eq("res_data", vrf_if.rdata[0], pat(7, 0));
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
